// File: rtl/vga_timing_generator.sv
// Raster timing generator: HSYNC/VSYNC, display enable, active-area X/Y
// and line/frame start strobes, all decoded from next-state counters.
module vga_timing_generator #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 10
) (
  input  logic             Pixelclock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             display_enable,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS =
    CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS =
    CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de;
  logic             w_h_zero;
  logic             w_v_zero;

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (enable) begin
      if (restart) begin
        w_h_nxt = '0;
        w_v_nxt = '0;
      end else if (r_h == H_LAST) begin
        w_h_nxt = '0;
        if (r_v == V_LAST) begin
          w_v_nxt = '0;
        end else begin
          w_v_nxt = r_v + CNT_W'(1);
        end
      end else begin
        w_h_nxt = r_h + CNT_W'(1);
      end
    end
  end

  // Outputs decode the next position so they never lag the counters.
  assign w_hs_act = (w_h_nxt >= HS_BEG) &&
                    (w_h_nxt < HS_END);
  assign w_vs_act = (w_v_nxt >= VS_BEG) &&
                    (w_v_nxt < VS_END);
  assign w_de     = (w_h_nxt < H_VIS) &&
                    (w_v_nxt < V_VIS);
  assign w_h_zero = (w_h_nxt == '0);
  assign w_v_zero = (w_v_nxt == '0);

  always_ff @(posedge Pixelclock or negedge reset) begin
    if (!reset) begin
      r_h            <= H_LAST;
      r_v            <= V_LAST;
      HSYNC          <= ~HSYNC_POL;
      VSYNC          <= ~VSYNC_POL;
      display_enable <= 1'b0;
      X              <= '0;
      Y              <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      r_h            <= w_h_nxt;
      r_v            <= w_v_nxt;
      HSYNC          <= w_hs_act ? HSYNC_POL
                                 : ~HSYNC_POL;
      VSYNC          <= w_vs_act ? VSYNC_POL
                                 : ~VSYNC_POL;
      display_enable <= w_de;
      X              <= w_de ? w_h_nxt : '0;
      Y              <= w_de ? w_v_nxt : '0;
      line_start     <= enable && w_h_zero;
      frame_start    <= enable && w_h_zero &&
                        w_v_zero;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: small-raster instances of both sync
// polarities plus a default-parameter instance checked over one line.
module tb_vga_timing_generator;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int HT = 15;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = 10;

  logic clk;
  logic rst_n;
  logic en;
  logic rs;

  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .CNT_W(10)
  ) u_a (
    .Pixelclock(clk), .reset(rst_n),
    .enable(en), .restart(rs),
    .HSYNC(a_hs), .VSYNC(a_vs),
    .display_enable(a_de),
    .X(a_x), .Y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .CNT_W(10)
  ) u_b (
    .Pixelclock(clk), .reset(rst_n),
    .enable(en), .restart(rs),
    .HSYNC(b_hs), .VSYNC(b_vs),
    .display_enable(b_de),
    .X(b_x), .Y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_generator u_c (
    .Pixelclock(clk), .reset(rst_n),
    .enable(en), .restart(rs),
    .HSYNC(c_hs), .VSYNC(c_vs),
    .display_enable(c_de),
    .X(c_x), .Y(c_y),
    .line_start(c_ls), .frame_start(c_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int mh;
  int mv;
  int e_ls;
  int e_fs;
  int cyc;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int de, hsa, vsa;
    de  = (mh < 8) && (mv < 6);
    hsa = (mh >= 10) && (mh < 13);
    vsa = (mv >= 7) && (mv < 9);
    chk("a_hs", 32'(a_hs), hsa ? 0 : 1);
    chk("a_vs", 32'(a_vs), vsa ? 0 : 1);
    chk("a_de", 32'(a_de), de);
    chk("a_x", 32'(a_x), de ? mh : 0);
    chk("a_y", 32'(a_y), de ? mv : 0);
    chk("a_ls", 32'(a_ls), e_ls);
    chk("a_fs", 32'(a_fs), e_fs);
    chk("b_hs", 32'(b_hs), hsa ? 1 : 0);
    chk("b_vs", 32'(b_vs), vsa ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && en) begin
      if (rs) begin
        mh = 0;
        mv = 0;
      end else if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e_ls = (mh == 0);
      e_fs = (mh == 0) && (mv == 0);
    end else begin
      e_ls = 0;
      e_fs = 0;
    end
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    int c_low, c_first, c_de_n, a_de_n;
    int last_fs, last_fall, prev_hs, n;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    mh     = HT - 1;
    mv     = VT - 1;
    e_ls   = 0;
    e_fs   = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    rs     = 1'b0;
    repeat (3) tick();
    chk("rst_c_hs", 32'(c_hs), 1);
    chk("rst_c_x", 32'(c_x), 0);

    // Free run after release
    #1;
    rst_n   = 1'b1;
    en      = 1'b1;
    c_low   = 0;
    c_first = -1;
    c_de_n  = 0;
    a_de_n  = 0;
    last_fs = -1;
    for (int k = 0; k < 900; k++) begin
      tick();
      if (k == 0) begin
        chk("first_fs", 32'(a_fs), 1);
        chk("first_ls", 32'(a_ls), 1);
        chk("first_de", 32'(a_de), 1);
      end
      if (k < 150) a_de_n += a_de;
      if (a_fs) begin
        if (last_fs >= 0)
          chk("fs_period", k - last_fs, 150);
        last_fs = k;
      end
      if (k < 800) begin
        c_de_n += c_de;
        if (!c_hs) begin
          c_low++;
          if (c_first < 0) c_first = k;
        end
      end
      if (k == 639) chk("c_x639", 32'(c_x), 639);
      if (k == 640) begin
        chk("c_x640", 32'(c_x), 0);
        chk("c_de640", 32'(c_de), 0);
      end
    end
    chk("a_de_frame", a_de_n, 48);
    chk("c_hs_low", c_low, 96);
    chk("c_hs_first", c_first, 656);
    chk("c_de_line", c_de_n, 640);

    // Half-rate enable
    last_fall = -1;
    prev_hs   = a_hs;
    for (int i = 0; i < 100; i++) begin
      en = (i % 2 == 0);
      tick();
      if (prev_hs && !a_hs) begin
        if (last_fall >= 0)
          chk("hs_period_en", cyc - last_fall, 30);
        last_fall = cyc;
      end
      prev_hs = a_hs;
    end
    en = 1'b1;

    // Restart from inside the sync region
    n = 0;
    while (!(mh == 12 && mv == 4) && n < 300) begin
      tick();
      n++;
    end
    chk("rs_reach", n < 300, 1);
    rs = 1'b1;
    tick();
    rs = 1'b0;
    chk("rs_fs", 32'(a_fs), 1);
    chk("rs_x", 32'(a_x), 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_fs && n < 200);
    chk("rs_frame", n, 150);

    // Asynchronous reset mid-frame
    n = 0;
    while (!(mh == 5 && mv == 3) && n < 300) begin
      tick();
      n++;
    end
    chk("mr_reach", n < 300, 1);
    chk("mr_x_pre", 32'(a_x), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_hs", 32'(a_hs), 1);
    chk("mr_vs", 32'(a_vs), 1);
    chk("mr_de", 32'(a_de), 0);
    chk("mr_x", 32'(a_x), 0);
    chk("mr_b_hs", 32'(b_hs), 0);
    mh = HT - 1;
    mv = VT - 1;
    repeat (2) tick();
    #1;
    rst_n = 1'b1;
    tick();
    chk("mr_fs", 32'(a_fs), 1);
    chk("mr_y", 32'(a_y), 0);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
